// File: rtl/rv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_arb
// Purpose  : Single-port SRAM arbiter for RV32I fetch and data accesses, with
//            store lane steering and load extraction. Define RV_MEM_ARB_RR_EN
//            for round-robin arbitration; otherwise data beats fetch.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_gnt,
   output logic          o_if_rvalid,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_dm_req,
   input  logic          i_dm_we,
   input  logic [AW-1:0] i_dm_addr,
   input  logic [DW-1:0] i_dm_wdata,
   input  logic [2:0]    i_dm_bytectrl,
   output logic          o_dm_gnt,
   output logic          o_dm_rvalid,
   output logic [DW-1:0] o_dm_rdata,
   output logic          o_dm_err,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [3:0]    o_mem_be,
   output logic [AW-3:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata
);

   localparam logic [2:0] c_BC_BYTE  = 3'b000;
   localparam logic [2:0] c_BC_HALF  = 3'b001;
   localparam logic [2:0] c_BC_WORD  = 3'b010;
   localparam logic [2:0] c_BC_BYTEU = 3'b100;
   localparam logic [2:0] c_BC_HALFU = 3'b101;

   function automatic logic f_misaligned(input logic [2:0] bc, input logic [1:0] off);
      case (bc)
         c_BC_BYTE, c_BC_BYTEU: f_misaligned = 1'b0;
         c_BC_HALF, c_BC_HALFU: f_misaligned = off[0];
         default:               f_misaligned = |off;
      endcase
   endfunction

   logic          w_dm_req;
   logic          w_if_req;
   logic          w_dm_gnt;
   logic          w_if_gnt;
   logic          w_dm_mis;
   logic          w_store;
   logic          w_p_mis;
   logic [3:0]    w_be;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_load;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic          w_unused_addr;

   logic          r_p_vld;
   logic          r_p_own;   // 1 = data port owns the pending read
   logic [1:0]    r_p_off;
   logic [2:0]    r_p_bc;

   // Requests are masked during reset so every output reads 0.
   assign w_dm_req      = i_dm_req & i_rstn;
   assign w_if_req      = i_if_req & i_rstn;
   assign w_unused_addr = ^i_if_addr[1:0];

`ifdef RV_MEM_ARB_RR_EN
   logic r_rr_ptr;   // 1 = fetch wins the next contended cycle

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rr_ptr <= 1'b0;
      end else if (w_dm_req && w_if_req) begin
         r_rr_ptr <= w_dm_gnt;
      end
   end

   assign w_dm_gnt = w_dm_req & (~w_if_req | ~r_rr_ptr);
`else
   assign w_dm_gnt = w_dm_req;
`endif
   assign w_if_gnt = w_if_req & ~w_dm_gnt;

   assign w_dm_mis = f_misaligned(i_dm_bytectrl, i_dm_addr[1:0]);
   assign w_store  = w_dm_gnt & i_dm_we;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_dm_wdata;
      case (i_dm_bytectrl)
         c_BC_BYTE, c_BC_BYTEU: begin
            w_be    = 4'b0001 << i_dm_addr[1:0];
            w_wdata = {4{i_dm_wdata[7:0]}};
         end
         c_BC_HALF, c_BC_HALFU: begin
            w_be    = i_dm_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_dm_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_dm_wdata;
         end
      endcase
   end

   assign o_dm_gnt    = w_dm_gnt;
   assign o_if_gnt    = w_if_gnt;
   assign o_mem_en    = w_if_gnt | (w_dm_gnt & ~w_dm_mis);
   assign o_mem_we    = w_store & ~w_dm_mis;
   assign o_mem_be    = o_mem_we ? w_be : 4'b0000;
   assign o_mem_wdata = o_mem_we ? w_wdata : '0;

   always_comb begin
      o_mem_addr = '0;
      if (w_dm_gnt) begin
         o_mem_addr = i_dm_addr[AW-1:2];
      end else if (w_if_gnt) begin
         o_mem_addr = i_if_addr[AW-1:2];
      end
   end

   // Pending register is rewritten every cycle; only reads leave it valid.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_p_vld <= 1'b0;
         r_p_own <= 1'b0;
         r_p_off <= 2'b00;
         r_p_bc  <= 3'b000;
      end else begin
         r_p_vld <= w_if_gnt | (w_dm_gnt & ~i_dm_we);
         r_p_own <= w_dm_gnt;
         r_p_off <= w_dm_gnt ? i_dm_addr[1:0] : 2'b00;
         r_p_bc  <= w_dm_gnt ? i_dm_bytectrl : c_BC_WORD;
      end
   end

   assign o_if_rvalid = i_rstn & r_p_vld & ~r_p_own;
   assign o_dm_rvalid = i_rstn & r_p_vld & r_p_own;
   assign w_p_mis     = f_misaligned(r_p_bc, r_p_off);

   assign w_byte = i_mem_rdata[{r_p_off, 3'b000} +: 8];
   assign w_half = r_p_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      w_load = i_mem_rdata;
      case (r_p_bc)
         c_BC_BYTE:  w_load = {{24{w_byte[7]}}, w_byte};
         c_BC_BYTEU: w_load = {24'h000000, w_byte};
         c_BC_HALF:  w_load = {{16{w_half[15]}}, w_half};
         c_BC_HALFU: w_load = {16'h0000, w_half};
         default:    w_load = i_mem_rdata;
      endcase
   end

   // A misaligned load answers with zero data and the error flag.
   assign o_dm_rdata = (o_dm_rvalid & ~w_p_mis) ? w_load : '0;
   assign o_dm_err   = (w_store & w_dm_mis) | (o_dm_rvalid & w_p_mis);
   assign o_if_rdata = i_rstn ? i_mem_rdata : '0;

endmodule
`default_nettype wire
